// File: rtl/mac_violation_ctrl_pkg.sv
// mac_violation_ctrl_pkg: FSM encoding, cause bit indices and parameter defaults
package mac_violation_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE, LOCKED} state_e;
  localparam int C_DATA = 0;
  localparam int C_TEXT = 1;
  localparam int C_WRITE = 2;
  localparam int C_JMP = 3;
  localparam int HOLD_CYCLES_DEF = 16;
  localparam int LOCK_THRESH_DEF = 4;
endpackage

// File: rtl/mac_hold_timer.sv
// mac_hold_timer: loadable down-counter timing the cpu_reset hold window
module mac_hold_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? 8'd0 : cnt_d;
  assign zero = cnt_q == 8'd0;
endmodule

// File: rtl/mac_violation_ctrl.sv
// mac_violation_ctrl: logs access violations, pulses/holds cpu_reset and locks after repeated violations
module mac_violation_ctrl
  import mac_violation_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int LOCK_THRESH = LOCK_THRESH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        viol_data,
  input  logic        viol_text,
  input  logic        viol_write,
  input  logic        viol_jmp,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic [15:0] code_addr,
  input  logic        clr_req,
  output logic        clr_ack,
  output logic        cpu_reset,
  output logic [3:0]  cause,
  output logic [15:0] log_pc,
  output logic [15:0] log_addr,
  output logic [7:0]  viol_cnt,
  output logic        locked
);
  state_e state_q, state_d;
  logic cpu_reset_q, cpu_reset_d, clr_ack_q, clr_ack_d, clr_done_q, clr_done_d;
  logic [3:0] cause_q, cause_d, viol_vec;
  logic [15:0] log_pc_q, log_pc_d, log_addr_q, log_addr_d;
  logic [7:0] viol_cnt_q, viol_cnt_d, cnt_inc;
  logic viol, take, clr_go, zero;
  mac_hold_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take),
    .dec      (state_q == HOLD),
    .load_val (8'(HOLD_CYCLES - 1)),
    .zero     (zero)
  );
  always_comb begin
    viol_vec = '0;
    viol_vec[C_DATA] = viol_data;
    viol_vec[C_TEXT] = viol_text;
    viol_vec[C_WRITE] = viol_write;
    viol_vec[C_JMP] = viol_jmp;
    viol = |viol_vec;
    cnt_inc = viol_cnt_q == 8'hff ? viol_cnt_q : viol_cnt_q + 8'd1;
    take = state_q == IDLE && viol;
    clr_go = state_q == IDLE && !viol && clr_req && !clr_done_q;
    state_d = state_q;
    cpu_reset_d = cpu_reset_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = cnt_inc >= 8'(LOCK_THRESH) ? LOCKED : HOLD;
        cpu_reset_d = 1'b1;
      end
      HOLD: if (zero) begin
        state_d = RELEASE;
        cpu_reset_d = 1'b0;
      end
      RELEASE: state_d = IDLE;
      default: cpu_reset_d = 1'b1;
    endcase
    cause_d = take ? viol_vec : clr_go ? 4'd0 : cause_q;
    log_pc_d = take ? pc : clr_go ? 16'd0 : log_pc_q;
    log_addr_d = take ? (viol_data ? data_addr : (viol_text || viol_write) ? code_addr : pc)
               : clr_go ? 16'd0 : log_addr_q;
    viol_cnt_d = take ? cnt_inc : clr_go ? 8'd0 : viol_cnt_q;
    clr_ack_d = clr_go;
    clr_done_d = clr_go || (clr_req && clr_done_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cpu_reset_q <= 1'b0;
      clr_ack_q <= 1'b0;
      clr_done_q <= 1'b0;
      cause_q <= 4'd0;
      log_pc_q <= 16'd0;
      log_addr_q <= 16'd0;
      viol_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cpu_reset_q <= cpu_reset_d;
      clr_ack_q <= clr_ack_d;
      clr_done_q <= clr_done_d;
      cause_q <= cause_d;
      log_pc_q <= log_pc_d;
      log_addr_q <= log_addr_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end
  assign clr_ack = clr_ack_q;
  assign cpu_reset = cpu_reset_q;
  assign cause = cause_q;
  assign log_pc = log_pc_q;
  assign log_addr = log_addr_q;
  assign viol_cnt = viol_cnt_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_mac_violation_ctrl.sv
// tb_mac_violation_ctrl: cycle-model scoreboard plus directed checks for mac_violation_ctrl
module tb_mac_violation_ctrl;
  logic clk = 0, rst_n = 0, clr_req = 0;
  logic viol_data = 0, viol_text = 0, viol_write = 0, viol_jmp = 0;
  logic [15:0] pc = 0, data_addr = 0, code_addr = 0;
  logic clr_ack, cpu_reset, locked;
  logic [3:0] cause;
  logic [15:0] log_pc, log_addr;
  logic [7:0] viol_cnt;
  int n_chk = 0, n_bad = 0, hi;
  logic [63:0] sb_q[$];
  logic m_lock = 0, m_rel = 0, m_ack = 0, m_done = 0;
  int m_left = 0;
  logic [3:0] m_cause = 0;
  logic [15:0] m_pc = 0, m_addr = 0;
  logic [7:0] m_cnt = 0;
  always #5 clk = ~clk;
  mac_violation_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .viol_data  (viol_data),
    .viol_text  (viol_text),
    .viol_write (viol_write),
    .viol_jmp   (viol_jmp),
    .pc         (pc),
    .data_addr  (data_addr),
    .code_addr  (code_addr),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .cpu_reset  (cpu_reset),
    .cause      (cause),
    .log_pc     (log_pc),
    .log_addr   (log_addr),
    .viol_cnt   (viol_cnt),
    .locked     (locked)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] v, input logic c);
    {viol_jmp, viol_write, viol_text, viol_data} = v;
    clr_req = c;
  endtask
  task automatic cyc();
    logic [3:0] v;
    v = {viol_jmp, viol_write, viol_text, viol_data};
    if (!rst_n) begin
      m_lock = 0; m_left = 0; m_rel = 0; m_ack = 0; m_done = 0;
      m_cause = 0; m_pc = 0; m_addr = 0; m_cnt = 0;
    end else begin
      m_ack = 0;
      if (m_lock) begin
      end else if (m_left != 0) begin
        m_left--;
        if (m_left == 0) m_rel = 1;
      end else if (m_rel) m_rel = 0;
      else if (v != 0) begin
        m_cause = v;
        m_pc = pc;
        m_addr = viol_data ? data_addr : (viol_text | viol_write) ? code_addr : pc;
        if (m_cnt != 8'hff) m_cnt++;
        if (m_cnt >= 4) m_lock = 1;
        else m_left = 16;
      end else if (clr_req && !m_done) begin
        m_cause = 0; m_pc = 0; m_addr = 0; m_cnt = 0;
        m_ack = 1; m_done = 1;
      end
      if (!clr_req) m_done = 0;
    end
    sb_q.push_back(64'({m_lock || m_left != 0, m_ack, m_lock, m_cause, m_pc, m_addr, m_cnt}));
    @(posedge clk);
    #1;
    chk("cyc", 64'({cpu_reset, clr_ack, locked, cause, log_pc, log_addr, viol_cnt}), sb_q.pop_front());
  endtask
  task automatic wait_ack();
    for (int i = 0; i < 40 && !clr_ack; i++) cyc();
    chk("ack_seen", clr_ack, 1);
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst", 64'({cpu_reset, clr_ack, locked, cause, log_pc, log_addr, viol_cnt}), 0);
    rst_n = 1;
    cyc();
    pc = 16'h1234; data_addr = 16'h0600; code_addr = 16'h0bad;
    drive(4'b0001, 0); cyc(); drive(0, 0);
    chk("v1_cause", cause, 4'b0001);
    chk("v1_addr", log_addr, 16'h0600);
    chk("v1_pc", log_pc, 16'h1234);
    chk("v1_cnt", viol_cnt, 1);
    hi = int'(cpu_reset);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) drive(4'b0010, 0);
      cyc(); drive(0, 0);
      hi += int'(cpu_reset);
    end
    chk("hold_len", 64'(hi), 16);
    chk("release_low", cpu_reset, 0);
    pc = 16'h5555; code_addr = 16'h7777;
    drive(4'b0100, 0); cyc(); drive(0, 0);
    chk("rel_ign_cnt", viol_cnt, 1);
    chk("rel_ign_addr", log_addr, 16'h0600);
    cyc();
    pc = 16'hA010; code_addr = 16'hA010; data_addr = 16'h1111;
    drive(4'b1010, 0); cyc(); drive(0, 0);
    chk("v2_cause", cause, 4'b1010);
    chk("v2_addr", log_addr, 16'hA010);
    chk("v2_cnt", viol_cnt, 2);
    repeat (4) cyc();
    drive(0, 1);
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("no_ack_hold", clr_ack, 0);
    end
    wait_ack();
    chk("clr_cnt", viol_cnt, 0);
    chk("clr_cause", cause, 0);
    repeat (3) cyc();
    chk("no_reack", clr_ack, 0);
    drive(0, 0); cyc();
    pc = 16'h0042; data_addr = 16'h0300;
    drive(4'b0001, 0); cyc(); drive(0, 0);
    repeat (10) cyc();
    rst_n = 0; cyc(); rst_n = 1;
    chk("mid_rst", 64'({cpu_reset, locked, viol_cnt}), 0);
    cyc();
    drive(4'b1000, 0); cyc(); drive(0, 0);
    hi = int'(cpu_reset);
    for (int i = 1; i <= 17; i++) begin
      cyc();
      hi += int'(cpu_reset);
    end
    chk("post_rst_len", 64'(hi), 16);
    chk("post_rst_cnt", viol_cnt, 1);
    drive(4'b0100, 1); cyc(); drive(0, 1);
    chk("sim_cnt", viol_cnt, 2);
    chk("sim_noack", clr_ack, 0);
    wait_ack();
    chk("sim_clr", viol_cnt, 0);
    drive(0, 0); cyc();
    for (int n = 0; n < 4; n++) begin
      pc = 16'(16'h0100 + n);
      drive(4'b0001, 0); cyc(); drive(0, 0);
      if (n < 3) repeat (19) cyc();
    end
    chk("lock", locked, 1);
    chk("lock_rst", cpu_reset, 1);
    chk("lock_cnt", viol_cnt, 4);
    drive(4'b1111, 1);
    repeat (25) begin
      cyc();
      chk("lock_noack", clr_ack, 0);
    end
    chk("lock_hold", 64'({locked, cpu_reset, viol_cnt}), 64'({1'b1, 1'b1, 8'd4}));
    drive(0, 0);
    rst_n = 0; cyc(); rst_n = 1;
    chk("unlock", 64'({cpu_reset, clr_ack, locked, cause, log_pc, log_addr, viol_cnt}), 0);
    drive(4'b0001, 0); cyc(); drive(0, 0);
    chk("first_after", 64'({cpu_reset, locked, viol_cnt}), 64'({1'b1, 1'b0, 8'd1}));
    for (int i = 0; i < 600; i++) begin
      pc = 16'($urandom); data_addr = 16'($urandom); code_addr = 16'($urandom);
      drive(($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
            ($urandom_range(0, 7) == 0) ? ~clr_req : clr_req);
      rst_n = $urandom_range(0, 59) != 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
